// File: rtl/vec_alu_pkg.sv
// vec_alu_pkg: shared types and constants for the multi-cycle vector ALU.
//   op_e    ALU operation encoding (ALUControl)
//   mode_e  operand B source (VSIFlag); 2'b11 falls back to VV
//   state_e engine FSM states
//   FLAG_Z / FLAG_N  bit positions inside the 2-bit flag vector
package vec_alu_pkg;
    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4,
        SHL = 3'd5,
        SHR = 3'd6,
        MUL = 3'd7
    } op_e;
    typedef enum logic [1:0] {
        VV = 2'd0,
        VS = 2'd1,
        VI = 2'd2
    } mode_e;
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_e;
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
endpackage

// File: rtl/vec_alu_lane.sv
// vec_alu_lane: combinational single-element ALU.
//   a, b   in   N-bit operands
//   op     in   3-bit op_e encoding
//   res    out  N-bit result
//   flags  out  {Nf, Z} of res
// Build option: VEC_ALU_SAT_EN makes ADD/SUB saturate unsigned instead of wrapping.
module vec_alu_lane
    import vec_alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic [N-1:0] res,
    output logic [1:0]   flags
);
    logic [N-1:0] add_r, sub_r;
`ifdef VEC_ALU_SAT_EN
    logic [N:0] sum, dif;
    assign sum   = {1'b0, a} + {1'b0, b};
    assign dif   = {1'b0, a} - {1'b0, b};
    // carry out clamps high, borrow clamps low
    assign add_r = sum[N] ? '1 : sum[N-1:0];
    assign sub_r = dif[N] ? '0 : dif[N-1:0];
`else
    assign add_r = a + b;
    assign sub_r = a - b;
`endif
    logic big_shift;
    assign big_shift = 32'(b) >= N;
    always_comb begin
        case (op_e'(op))
            ADD:     res = add_r;
            SUB:     res = sub_r;
            AND:     res = a & b;
            OR:      res = a | b;
            XOR:     res = a ^ b;
            SHL:     res = big_shift ? '0 : a << b;
            SHR:     res = big_shift ? '0 : a >> b;
            MUL:     res = a * b;
            default: res = '0;
        endcase
    end
    assign flags[FLAG_Z] = res == '0;
    assign flags[FLAG_N] = res[N-1];
endmodule

// File: rtl/vec_alu_engine.sv
// vec_alu_engine: multi-cycle vector ALU, LANES elements per beat over ELEMS/LANES beats.
//   clk, rst(async, active-low)
//   in_valid/in_ready    operand handshake: SrcA, SrcB, SrcBi, Imm, ALUControl, VSIFlag
//   out_valid/out_ready  result handshake: ALUOutput, ALUFlags {Nf,Z} of element 0, ZeroMask
// Build option: VEC_ALU_SAT_EN selects saturating ADD/SUB inside vec_alu_lane.
module vec_alu_engine
    import vec_alu_pkg::*;
#(
    parameter int N     = 8,
    parameter int LANES = 6,
    parameter int ELEMS = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ELEMS-1:0][N-1:0]     SrcA,
    input  logic [ELEMS-1:0][N-1:0]     SrcB,
    input  logic [$clog2(ELEMS)-1:0]    SrcBi,
    input  logic [N-1:0]                Imm,
    input  logic [2:0]                  ALUControl,
    input  logic [1:0]                  VSIFlag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ELEMS-1:0][N-1:0]     ALUOutput,
    output logic [1:0]                  ALUFlags,
    output logic [ELEMS-1:0]            ZeroMask
);
    localparam int BEATS = ELEMS / LANES;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int IW    = $clog2(ELEMS);

    state_e                 state_q, state_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [ELEMS-1:0][N-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]             op_q, op_d;
    logic [ELEMS-1:0]       zmask_q, zmask_d;
    logic [1:0]             flags_q, flags_d;
    logic                   accept, last_beat;
    logic [N-1:0]           scalar;

    logic [IW-1:0] lane_idx   [LANES];
    logic [N-1:0]  lane_res   [LANES];
    logic [1:0]    lane_flags [LANES];
    logic [LANES-1:0] lane_nf;
    logic unused_nf;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = IW'(int'(beat_q) * LANES + l);
        vec_alu_lane #(.N(N)) u_lane (
            .a     (a_q[lane_idx[l]]),
            .b     (b_q[lane_idx[l]]),
            .op    (op_q),
            .res   (lane_res[l]),
            .flags (lane_flags[l])
        );
        assign lane_nf[l] = lane_flags[l][FLAG_N];
    end
    // only element 0 contributes Nf to ALUFlags
    assign unused_nf = ^lane_nf;

    assign scalar    = (32'(SrcBi) >= ELEMS) ? '0 : SrcB[SrcBi];
    assign last_beat = beat_q == BW'(BEATS - 1);

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        res_d    = res_q;
        zmask_d  = zmask_q;
        flags_d  = flags_q;
        in_ready = state_q == IDLE || (state_q == HOLD && out_ready);
        accept   = in_valid && in_ready;
        if (state_q == RUN) begin
            for (int l = 0; l < LANES; l++) begin
                res_d[lane_idx[l]]   = lane_res[l];
                zmask_d[lane_idx[l]] = lane_flags[l][FLAG_Z];
            end
            flags_d = beat_q == '0 ? lane_flags[0] : flags_q;
            beat_d  = last_beat ? '0 : beat_q + 1'b1;
            state_d = last_beat ? HOLD : RUN;
        end else if (state_q == HOLD && out_ready) begin
            state_d = IDLE;
        end
        // operand B is resolved to a full vector at accept so lanes never see the mode
        if (accept) begin
            state_d = RUN;
            beat_d  = '0;
            a_d     = SrcA;
            op_d    = ALUControl;
            b_d     = VSIFlag == VS ? {ELEMS{scalar}} :
                      VSIFlag == VI ? {ELEMS{Imm}}    : SrcB;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            zmask_q <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zmask_q <= zmask_d;
            flags_q <= flags_d;
        end
    end

    assign out_valid = state_q == HOLD;
    assign ALUOutput = res_q;
    assign ALUFlags  = flags_q;
    assign ZeroMask  = zmask_q;
endmodule

// File: tb/tb_vec_alu_engine.sv
// tb_vec_alu_engine: directed self-checking bench for vec_alu_engine (N=8, LANES=6, ELEMS=12).
module tb_vec_alu_engine;
    logic        clk = 0;
    logic        rst = 0;
    logic        in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic [95:0] SrcA = '0, SrcB = '0, ALUOutput;
    logic [3:0]  SrcBi = '0;
    logic [7:0]  Imm = '0;
    logic [2:0]  ALUControl = '0;
    logic [1:0]  VSIFlag = '0, ALUFlags;
    logic [11:0] ZeroMask;
    int checks = 0, passed = 0;

    vec_alu_engine #(.N(8), .LANES(6), .ELEMS(12)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .SrcA(SrcA), .SrcB(SrcB), .SrcBi(SrcBi), .Imm(Imm),
        .ALUControl(ALUControl), .VSIFlag(VSIFlag),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUOutput(ALUOutput), .ALUFlags(ALUFlags), .ZeroMask(ZeroMask)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] fill(input logic [7:0] v);
        logic [95:0] r;
        for (int i = 0; i < 12; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    task automatic send(input logic [95:0] a, input logic [95:0] b, input logic [3:0] bi,
                        input logic [7:0] imm, input logic [2:0] op, input logic [1:0] mode);
        SrcA = a; SrcB = b; SrcBi = bi; Imm = imm; ALUControl = op; VSIFlag = mode;
        in_valid = 1;
        for (int k = 0; k < 20 && !in_ready; k++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = -1;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) begin cyc = k; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic retire();
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", out_valid); else passed++;
        checks++; if (ALUOutput !== 96'h0) $display("FAIL reset_out: got %h exp 0", ALUOutput); else passed++;
        checks++; if (ALUFlags !== 2'b00) $display("FAIL reset_flags: got %b exp 00", ALUFlags); else passed++;
        checks++; if (ZeroMask !== 12'h0) $display("FAIL reset_zmask: got %h exp 0", ZeroMask); else passed++;
        rst = 1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", in_ready); else passed++;
    endtask

    task automatic test_vv_add();
        logic [95:0] a, e;
        int cyc;
        for (int i = 0; i < 12; i++) begin a[i*8 +: 8] = 8'(i); e[i*8 +: 8] = 8'(i + 10); end
        send(a, fill(8'd10), 4'd0, 8'd0, 3'd0, 2'b00);
        checks++; if (out_valid !== 1'b0) $display("FAIL vv_add_early: got %b exp 0", out_valid); else passed++;
        wait_out(cyc);
        checks++; if (cyc !== 2) $display("FAIL vv_add_latency: got %0d exp 2", cyc); else passed++;
        checks++; if (ALUOutput !== e) $display("FAIL vv_add_out: got %h exp %h", ALUOutput, e); else passed++;
        checks++; if (ALUFlags !== 2'b00) $display("FAIL vv_add_flags: got %b exp 00", ALUFlags); else passed++;
        checks++; if (ZeroMask !== 12'h0) $display("FAIL vv_add_zmask: got %h exp 0", ZeroMask); else passed++;
        retire();
    endtask

    task automatic test_vs_sub();
        logic [95:0] b;
        int cyc;
        b = fill(8'd9);
        b[3*8 +: 8] = 8'd5;
        send(fill(8'd5), b, 4'd3, 8'd0, 3'd1, 2'b01);
        wait_out(cyc);
        checks++; if (ALUOutput !== 96'h0) $display("FAIL vs_sub_out: got %h exp 0", ALUOutput); else passed++;
        checks++; if (ZeroMask !== 12'hFFF) $display("FAIL vs_sub_zmask: got %h exp fff", ZeroMask); else passed++;
        checks++; if (ALUFlags !== 2'b01) $display("FAIL vs_sub_flags: got %b exp 01", ALUFlags); else passed++;
        retire();
        send(fill(8'd5), b, 4'd12, 8'd0, 3'd1, 2'b01);
        wait_out(cyc);
        checks++; if (ALUOutput !== fill(8'd5)) $display("FAIL vs_oob_out: got %h exp %h", ALUOutput, fill(8'd5)); else passed++;
        checks++; if (ZeroMask !== 12'h0) $display("FAIL vs_oob_zmask: got %h exp 0", ZeroMask); else passed++;
        retire();
    endtask

    task automatic test_vi();
        int cyc;
        send(fill(8'd250), fill(8'd1), 4'd0, 8'd10, 3'd0, 2'b10);
        wait_out(cyc);
`ifdef VEC_ALU_SAT_EN
        checks++; if (ALUOutput !== fill(8'd255)) $display("FAIL vi_add_out: got %h exp %h", ALUOutput, fill(8'd255)); else passed++;
        checks++; if (ALUFlags !== 2'b10) $display("FAIL vi_add_flags: got %b exp 10", ALUFlags); else passed++;
`else
        checks++; if (ALUOutput !== fill(8'd4)) $display("FAIL vi_add_out: got %h exp %h", ALUOutput, fill(8'd4)); else passed++;
        checks++; if (ALUFlags !== 2'b00) $display("FAIL vi_add_flags: got %b exp 00", ALUFlags); else passed++;
`endif
        retire();
        send(fill(8'd3), fill(8'd1), 4'd0, 8'd5, 3'd1, 2'b10);
        wait_out(cyc);
`ifdef VEC_ALU_SAT_EN
        checks++; if (ALUOutput !== 96'h0) $display("FAIL vi_sub_out: got %h exp 0", ALUOutput); else passed++;
        checks++; if (ALUFlags !== 2'b01) $display("FAIL vi_sub_flags: got %b exp 01", ALUFlags); else passed++;
        checks++; if (ZeroMask !== 12'hFFF) $display("FAIL vi_sub_zmask: got %h exp fff", ZeroMask); else passed++;
`else
        checks++; if (ALUOutput !== fill(8'd254)) $display("FAIL vi_sub_out: got %h exp %h", ALUOutput, fill(8'd254)); else passed++;
        checks++; if (ALUFlags !== 2'b10) $display("FAIL vi_sub_flags: got %b exp 10", ALUFlags); else passed++;
        checks++; if (ZeroMask !== 12'h0) $display("FAIL vi_sub_zmask: got %h exp 0", ZeroMask); else passed++;
`endif
        retire();
    endtask

    task automatic test_shift_mul_logic();
        int cyc;
        send(fill(8'hFF), fill(8'd9), 4'd0, 8'd0, 3'd5, 2'b00);
        wait_out(cyc);
        checks++; if (ALUOutput !== 96'h0) $display("FAIL shl_big_out: got %h exp 0", ALUOutput); else passed++;
        retire();
        send(fill(8'd16), fill(8'd16), 4'd0, 8'd0, 3'd7, 2'b00);
        wait_out(cyc);
        checks++; if (ALUOutput !== 96'h0) $display("FAIL mul_out: got %h exp 0", ALUOutput); else passed++;
        checks++; if (ALUFlags !== 2'b01) $display("FAIL mul_flags: got %b exp 01", ALUFlags); else passed++;
        retire();
        send(fill(8'h80), fill(8'd7), 4'd0, 8'd0, 3'd6, 2'b00);
        wait_out(cyc);
        checks++; if (ALUOutput !== fill(8'h01)) $display("FAIL shr_out: got %h exp %h", ALUOutput, fill(8'h01)); else passed++;
        retire();
        send(fill(8'h03), fill(8'd3), 4'd0, 8'd0, 3'd5, 2'b00);
        wait_out(cyc);
        checks++; if (ALUOutput !== fill(8'h18)) $display("FAIL shl_out: got %h exp %h", ALUOutput, fill(8'h18)); else passed++;
        retire();
        send(fill(8'hF0), fill(8'h3C), 4'd0, 8'd0, 3'd2, 2'b00);
        wait_out(cyc);
        checks++; if (ALUOutput !== fill(8'h30)) $display("FAIL and_out: got %h exp %h", ALUOutput, fill(8'h30)); else passed++;
        retire();
        send(fill(8'hF0), fill(8'h3C), 4'd0, 8'd0, 3'd3, 2'b00);
        wait_out(cyc);
        checks++; if (ALUOutput !== fill(8'hFC)) $display("FAIL or_out: got %h exp %h", ALUOutput, fill(8'hFC)); else passed++;
        checks++; if (ALUFlags !== 2'b10) $display("FAIL or_flags: got %b exp 10", ALUFlags); else passed++;
        retire();
        send(fill(8'hF0), fill(8'h3C), 4'd0, 8'd77, 3'd4, 2'b11);
        wait_out(cyc);
        checks++; if (ALUOutput !== fill(8'hCC)) $display("FAIL xor_mode3_out: got %h exp %h", ALUOutput, fill(8'hCC)); else passed++;
        retire();
    endtask

    task automatic test_back_to_back();
        logic [95:0] a, e1, a2, b2;
        int cyc;
        for (int i = 0; i < 12; i++) begin
            a[i*8 +: 8] = 8'(i); e1[i*8 +: 8] = 8'(i + 10);
            a2[i*8 +: 8] = 8'(i + 20); b2[i*8 +: 8] = 8'(i);
        end
        send(a, fill(8'd10), 4'd0, 8'd0, 3'd0, 2'b00);
        SrcA = fill(8'hAA); SrcB = fill(8'h55); ALUControl = 3'd7;
        wait_out(cyc);
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %b exp 1", k, out_valid); else passed++;
            checks++; if (in_ready !== 1'b0) $display("FAIL hold_ready[%0d]: got %b exp 0", k, in_ready); else passed++;
            checks++; if (ALUOutput !== e1) $display("FAIL hold_out[%0d]: got %h exp %h", k, ALUOutput, e1); else passed++;
            @(posedge clk); #1;
        end
        SrcA = a2; SrcB = b2; ALUControl = 3'd1; VSIFlag = 2'b00;
        in_valid = 1; out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready: got %b exp 1", in_ready); else passed++;
        @(posedge clk); #1;
        in_valid = 0; out_ready = 0;
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_run_valid: got %b exp 0", out_valid); else passed++;
        wait_out(cyc);
        checks++; if (cyc !== 2) $display("FAIL b2b_latency: got %0d exp 2", cyc); else passed++;
        checks++; if (ALUOutput !== fill(8'd20)) $display("FAIL b2b_out: got %h exp %h", ALUOutput, fill(8'd20)); else passed++;
        retire();
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        send(fill(8'd7), fill(8'd1), 4'd0, 8'd0, 3'd0, 2'b00);
        #2 rst = 0;
        #1;
        checks++; if (ALUOutput !== 96'h0) $display("FAIL mid_rst_out: got %h exp 0", ALUOutput); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b exp 0", out_valid); else passed++;
        checks++; if (ZeroMask !== 12'h0) $display("FAIL mid_rst_zmask: got %h exp 0", ZeroMask); else passed++;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b exp 1", in_ready); else passed++;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_discard: got %b exp 0", out_valid); else passed++;
        send(fill(8'h5A), fill(8'h0F), 4'd0, 8'd0, 3'd2, 2'b00);
        wait_out(cyc);
        checks++; if (cyc !== 2) $display("FAIL post_rst_latency: got %0d exp 2", cyc); else passed++;
        checks++; if (ALUOutput !== fill(8'h0A)) $display("FAIL post_rst_out: got %h exp %h", ALUOutput, fill(8'h0A)); else passed++;
        retire();
    endtask

    initial begin
        test_reset();
        test_vv_add();
        test_vs_sub();
        test_vi();
        test_shift_mul_logic();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
